key_counter_input: RTL and testbench

KEY_COUNTER_INPUT -- requirements
Module: key_counter_input

---
 rtl/key_counter_input.sv | 84 ++++++++
 tb/tb_key_counter_input.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/key_counter_input.sv
// key_counter_input: two debounced active-low keys driving a mod-M up/down counter.
// Define KEY_AUTO_REPEAT_EN to emit repeat ticks while a key stays held.
module key_counter_input #(
  parameter int DB_M  = 1000000,
  parameter int DB_N  = 20,
  parameter int M     = 12,
  parameter int N     = 4,
  parameter int RPT_M = 25000000,
  parameter int RPT_N = 25
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         key_up_n,
  input  logic         key_dn_n,
  output logic         up_tick,
  output logic         dn_tick,
  output logic [N-1:0] count,
  output logic         wrap_tick
);
  typedef enum logic [1:0] {IDLE, F_PRESS, HELD, F_REL} state_t;
  logic [1:0] raw, tk;
  assign raw = {key_dn_n, key_up_n};
  assign up_tick = tk[0];
  assign dn_tick = tk[1];
  if (DB_M < 2 || 2**DB_N < DB_M || 2**N < M || 2**RPT_N < RPT_M) begin : g_bad_params
  end
  for (genvar g = 0; g < 2; g++) begin : g_key
    logic s1, s2, t;
    state_t st;
    logic [DB_N-1:0] cnt;
`ifdef KEY_AUTO_REPEAT_EN
    logic [RPT_N-1:0] rpt;
`endif
    assign tk[g] = t;
    always_ff @(posedge CLOCK_50 or posedge reset)
      if (reset) begin
        s1 <= 1'b1;
        s2 <= 1'b1;
        t <= 1'b0;
        st <= IDLE;
        cnt <= '0;
`ifdef KEY_AUTO_REPEAT_EN
        rpt <= '0;
`endif
      end else begin
        s1 <= raw[g];
        s2 <= s1;
        t <= 1'b0;
        case (st)
          IDLE: if (!s2) begin st <= F_PRESS; cnt <= '0; end
          F_PRESS:
            if (s2) st <= IDLE;
            else if (cnt == DB_N'(DB_M - 2)) begin st <= HELD; t <= 1'b1; end
            else cnt <= cnt + DB_N'(1);
`ifdef KEY_AUTO_REPEAT_EN
          HELD:
            if (s2) begin st <= F_REL; cnt <= '0; rpt <= '0; end
            else if (rpt == RPT_N'(RPT_M - 1)) begin rpt <= '0; t <= 1'b1; end
            else rpt <= rpt + RPT_N'(1);
`else
          HELD: if (s2) begin st <= F_REL; cnt <= '0; end
`endif
          F_REL:
            if (!s2) st <= HELD;
            else if (cnt == DB_N'(DB_M - 2)) st <= IDLE;
            else cnt <= cnt + DB_N'(1);
          default: st <= IDLE;
        endcase
      end
  end
  logic inc, dec, top, bot;
  assign inc = up_tick & ~dn_tick;
  assign dec = dn_tick & ~up_tick;
  assign top = count == N'(M - 1);
  assign bot = count == '0;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      count <= '0;
      wrap_tick <= 1'b0;
    end else begin
      wrap_tick <= (inc & top) | (dec & bot);
      count <= inc ? (top ? '0 : count + N'(1)) : dec ? (bot ? N'(M - 1) : count - N'(1)) : count;
    end
endmodule

// File: tb/tb_key_counter_input.sv
// tb_key_counter_input: directed table and sequence checks of debounce, counting and reset.
module tb_key_counter_input;
  logic clk = 1'b0, reset = 1'b1, key_up_n = 1'b1, key_dn_n = 1'b1;
  logic up_tick, dn_tick, wrap_tick;
  logic [3:0] count;
  int checks = 0, errors = 0;
  int nu, nd, nb, nw;

  always #5 clk = ~clk;

  key_counter_input #(.DB_M(4), .DB_N(3), .M(12), .N(4), .RPT_M(10), .RPT_N(4)) dut (
    .CLOCK_50(clk), .reset(reset), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
    .up_tick(up_tick), .dn_tick(dn_tick), .count(count), .wrap_tick(wrap_tick)
  );

  typedef struct {
    logic up_n, dn_n;
    int cyc, n_up, n_dn, n_both, n_wrap, cnt;
  } seg_t;
  seg_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic u, input logic d, input int cyc, input int eu,
                              input int ed, input int eb, input int ew, input int ec);
    tbl.push_back('{u, d, cyc, eu, ed, eb, ew, ec});
  endfunction

  task automatic seg(input logic u, input logic d, input int cyc);
    key_up_n = u;
    key_dn_n = d;
    nu = 0; nd = 0; nb = 0; nw = 0;
    repeat (cyc) begin
      @(negedge clk);
      nu += int'(up_tick);
      nd += int'(dn_tick);
      nb += int'(up_tick & dn_tick);
      nw += int'(wrap_tick);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, first, n;
    int pos[$];
    for (int i = 0; i < 3; i++) begin
      add(1'b0, 1'b1, 3, 0, 0, 0, 0, 0);
      add(1'b1, 1'b1, 5, 0, 0, 0, 0, 0);
    end
    add(1'b0, 1'b1, 20, 1, 0, 0, 0, 1);
    add(1'b1, 1'b1, 20, 0, 0, 0, 0, 1);
    for (int i = 2; i <= 11; i++) begin
      add(1'b0, 1'b1, 10, 1, 0, 0, 0, i);
      add(1'b1, 1'b1, 10, 0, 0, 0, 0, i);
    end
    add(1'b0, 1'b1, 10, 1, 0, 0, 1, 0);
    add(1'b1, 1'b1, 10, 0, 0, 0, 0, 0);
    add(1'b1, 1'b0, 10, 0, 1, 0, 1, 11);
    add(1'b1, 1'b1, 10, 0, 0, 0, 0, 11);
    add(1'b0, 1'b0, 10, 1, 1, 1, 0, 11);
    add(1'b1, 1'b1, 10, 0, 0, 0, 0, 11);
    add(1'b1, 1'b0, 10, 0, 1, 0, 0, 10);
    add(1'b1, 1'b1, 10, 0, 0, 0, 0, 10);
    add(1'b0, 1'b1, 10, 1, 0, 0, 0, 11);
    add(1'b1, 1'b1, 10, 0, 0, 0, 0, 11);

    repeat (3) @(negedge clk);
    chk("reset_up_tick", int'(up_tick), 0);
    chk("reset_dn_tick", int'(dn_tick), 0);
    chk("reset_wrap", int'(wrap_tick), 0);
    chk("reset_count", int'(count), 0);
    reset = 1'b0;

    key_up_n = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30 && lat < 0; i++) begin
      @(negedge clk);
      if (up_tick) lat = i;
    end
    chk("press_latency", lat, 6);
    @(negedge clk);
    chk("count_after_tick", int'(count), 1);
    key_up_n = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_reset_count", int'(count), 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      seg(tbl[i].up_n, tbl[i].dn_n, tbl[i].cyc);
      chk($sformatf("seg%0d up_ticks", i), nu, tbl[i].n_up);
      chk($sformatf("seg%0d dn_ticks", i), nd, tbl[i].n_dn);
      chk($sformatf("seg%0d both", i), nb, tbl[i].n_both);
      chk($sformatf("seg%0d wraps", i), nw, tbl[i].n_wrap);
      chk($sformatf("seg%0d count", i), int'(count), tbl[i].cnt);
    end

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    key_up_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("fpress_no_tick_yet", int'(up_tick), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    first = -1;
    n = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (up_tick) begin
        n++;
        if (first < 0) first = i;
      end
    end
    chk("reset_fpress_first_tick", first, 6);
    chk("reset_fpress_ticks", n, 1);
    chk("reset_fpress_count", int'(count), 1);
    key_up_n = 1'b1;
    repeat (10) @(negedge clk);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    key_up_n = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30 && lat < 0; i++) begin
      @(negedge clk);
      if (up_tick) lat = i;
    end
    chk("repeat_press_latency", lat, 6);
    n = 1;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (up_tick) begin
        n++;
        pos.push_back(k);
      end
    end
    key_up_n = 1'b1;
    repeat (10) @(negedge clk);
`ifdef KEY_AUTO_REPEAT_EN
    chk("repeat_ticks", n, 4);
    chk("repeat_count", int'(count), 4);
    for (int j = 0; j < 3; j++) chk($sformatf("repeat_pos%0d", j), j < pos.size() ? pos[j] : -1, 10 * (j + 1));
`else
    chk("repeat_ticks", n, 1);
    chk("repeat_count", int'(count), 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
